// File: rtl/fp_add_normalize_pack_pkg.sv
// -----------------------------------------------------------------------------
// fp_add_pkg
//   Shared definitions for the FP adder normalize/pack stage: field widths,
//   the infinity exponent, result flag bit positions and the FSM state type.
//   No ports.
// -----------------------------------------------------------------------------
package fp_add_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int MANT_W  = 24;   // hidden bit + fraction
   localparam int SHIFT_W = 5;    // holds 0..24
   localparam int FLAG_W  = 3;

   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   localparam int FLAG_OVF  = 2;
   localparam int FLAG_UNF  = 1;
   localparam int FLAG_ZERO = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [31:0] pack_word(input logic           sign,
                                             input logic [EXP_W-1:0]  exp,
                                             input logic [FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp_add_normalize_pack_if.sv
// -----------------------------------------------------------------------------
// fp_add_normalize_pack_if
//   Handshake bundle around the normalize/pack stage.
//   Upstream side : in_valid/in_ready, in_sign, in_exp[7:0], in_mant[24:0]
//   Downstream    : out_valid/out_ready, out_result[31:0], out_flags[2:0],
//                   out_shift[4:0]
//   slave  : view taken by the stage itself
//   master : view taken by whatever drives the stage and consumes results
// -----------------------------------------------------------------------------
interface fp_add_normalize_pack_if;

   logic                               in_valid;
   logic                               in_ready;
   logic                               in_sign;
   logic [fp_add_pkg::EXP_W-1:0]       in_exp;
   logic [fp_add_pkg::MANT_W:0]        in_mant;
   logic                               out_valid;
   logic                               out_ready;
   logic [31:0]                        out_result;
   logic [fp_add_pkg::FLAG_W-1:0]      out_flags;
   logic [fp_add_pkg::SHIFT_W-1:0]     out_shift;

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_result, out_flags, out_shift
   );

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_result, out_flags, out_shift
   );

endinterface

// File: rtl/fp_add_normalize_pack_norm_step.sv
// -----------------------------------------------------------------------------
// fp_norm_step
//   One combinational left-normalize step. Passes everything through once the
//   hidden bit is set or underflow was already flagged earlier in the chain.
//   Ports:
//     i_mant/o_mant   [23:0] working mantissa (hidden bit at [23])
//     i_exp/o_exp     [7:0]  working biased exponent
//     i_shift/o_shift [4:0]  left shifts applied so far
//     i_unf/o_unf            underflow detected
// -----------------------------------------------------------------------------
module fp_norm_step
   import fp_add_pkg::*;
(
   input  logic [MANT_W-1:0]  i_mant,
   input  logic [EXP_W-1:0]   i_exp,
   input  logic [SHIFT_W-1:0] i_shift,
   input  logic               i_unf,
   output logic [MANT_W-1:0]  o_mant,
   output logic [EXP_W-1:0]   o_exp,
   output logic [SHIFT_W-1:0] o_shift,
   output logic               o_unf
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      o_mant  = i_mant;
      o_exp   = i_exp;
      o_shift = i_shift;
      o_unf   = i_unf;
      if (!i_unf && !i_mant[MANT_W-1]) begin
         // Exponent 1 is the smallest normal; one more shift would go subnormal.
         if (i_exp <= 8'd1) begin
            o_unf = 1'b1;
         end else begin
            o_mant  = i_mant << 1;
            o_exp   = i_exp - 8'd1;
            o_shift = i_shift + 5'd1;
         end
      end
   end

endmodule

// File: rtl/fp_add_normalize_pack.sv
// -----------------------------------------------------------------------------
// fp_add_normalize_pack
//   Normalizes the raw mantissa sum of the FP adder and packs an IEEE-754
//   single-precision word (truncation, no rounding). Carry and already-normal
//   sums, zero and infinity finish in one cycle; sums with leading zeros are
//   shifted left SHIFTS_PER_CYCLE bits per cycle until the hidden bit is set
//   or the exponent would leave the normal range (flush to zero).
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     io_bus   fp_add_normalize_pack_if.slave (valid/ready in and out)
// -----------------------------------------------------------------------------
module fp_add_normalize_pack
   import fp_add_pkg::*;
#(
   parameter int SHIFTS_PER_CYCLE = 1
)(
   input  logic                    clk,
   input  logic                    reset_n,
   fp_add_normalize_pack_if.slave  io_bus
);

   localparam int S = SHIFTS_PER_CYCLE;

   state_t               r_state;
   logic                 r_sign;
   logic [EXP_W-1:0]     r_exp;
   logic [MANT_W-1:0]    r_mant;
   logic [SHIFT_W-1:0]   r_shift;
   logic                 r_out_valid;
   logic [31:0]          r_result;
   logic [FLAG_W-1:0]    r_flags;
   logic [SHIFT_W-1:0]   r_out_shift;

   logic                 w_in_ready;
   logic                 w_accept;
   logic [EXP_W:0]       w_exp_inc;   // 9 bits so the step to FF is visible

   logic [MANT_W-1:0]    w_mant  [S+1];
   logic [EXP_W-1:0]     w_exp   [S+1];
   logic [SHIFT_W-1:0]   w_shift [S+1];
   logic                 w_unf   [S+1];

   assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && io_bus.out_ready);
   assign w_accept   = io_bus.in_valid && w_in_ready;
   assign w_exp_inc  = {1'b0, io_bus.in_exp} + 9'd1;

   assign io_bus.in_ready   = w_in_ready;
   assign io_bus.out_valid  = r_out_valid;
   assign io_bus.out_result = r_result;
   assign io_bus.out_flags  = r_flags;
   assign io_bus.out_shift  = r_out_shift;

   // Chain of single-bit steps evaluated within one NORM cycle.
   assign w_mant[0]  = r_mant;
   assign w_exp[0]   = r_exp;
   assign w_shift[0] = r_shift;
   assign w_unf[0]   = 1'b0;

   for (genvar g = 0; g < S; g++) begin : g_step
      fp_norm_step u_step (
         .i_mant  (w_mant[g]),
         .i_exp   (w_exp[g]),
         .i_shift (w_shift[g]),
         .i_unf   (w_unf[g]),
         .o_mant  (w_mant[g+1]),
         .o_exp   (w_exp[g+1]),
         .o_shift (w_shift[g+1]),
         .o_unf   (w_unf[g+1])
      );
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: work registers are reset along with the state so an abandoned
   // NORM pass leaves nothing behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mant      <= '0;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
         r_out_shift <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_flags     <= '0;
                  r_out_shift <= '0;
                  if (io_bus.in_exp == EXP_INF) begin
                     r_result          <= pack_word(io_bus.in_sign, EXP_INF, '0);
                     r_flags[FLAG_OVF] <= 1'b1;
                  end else if (io_bus.in_mant == '0) begin
                     r_result           <= '0;
                     r_flags[FLAG_ZERO] <= 1'b1;
                  end else if (io_bus.in_mant[MANT_W]) begin
                     if (w_exp_inc >= {1'b0, EXP_INF}) begin
                        r_result          <= pack_word(io_bus.in_sign, EXP_INF, '0);
                        r_flags[FLAG_OVF] <= 1'b1;
                     end else begin
                        r_result <= pack_word(io_bus.in_sign, w_exp_inc[EXP_W-1:0],
                                              io_bus.in_mant[MANT_W-1:1]);
                     end
                  end else if (io_bus.in_mant[MANT_W-1]) begin
                     r_result <= pack_word(io_bus.in_sign, io_bus.in_exp,
                                           io_bus.in_mant[FRAC_W-1:0]);
                  end else begin
                     r_state     <= NORM;
                     r_out_valid <= 1'b0;
                     r_sign      <= io_bus.in_sign;
                     r_exp       <= io_bus.in_exp;
                     r_mant      <= io_bus.in_mant[MANT_W-1:0];
                     r_shift     <= '0;
                  end
               end else if (r_state == DONE && io_bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end

            NORM: begin
               if (w_unf[S]) begin
                  r_state           <= DONE;
                  r_out_valid       <= 1'b1;
                  r_result          <= pack_word(r_sign, '0, '0);
                  r_flags           <= '0;
                  r_flags[FLAG_UNF] <= 1'b1;
                  r_out_shift       <= w_shift[S];
               end else if (w_mant[S][MANT_W-1]) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= pack_word(r_sign, w_exp[S], w_mant[S][FRAC_W-1:0]);
                  r_flags     <= '0;
                  r_out_shift <= w_shift[S];
               end else begin
                  r_mant  <= w_mant[S];
                  r_exp   <= w_exp[S];
                  r_shift <= w_shift[S];
               end
            end

            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_normalize_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_add_normalize_pack
//   Drives two instances (1 and 4 shifts per cycle) through a shared stimulus
//   bus; sel picks which instance sees valid/ready and whose outputs are read.
//   Expected values come from an arithmetic model of the stage.
// -----------------------------------------------------------------------------
module tb_fp_add_normalize_pack;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sel = 1'b0;        // 0: S=1 instance, 1: S=4 instance
   logic        d_valid = 1'b0;
   logic        d_sign = 1'b0;
   logic [7:0]  d_exp = '0;
   logic [24:0] d_mant = '0;
   logic        d_out_ready = 1'b1;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   fp_add_normalize_pack_if if1 ();
   fp_add_normalize_pack_if if4 ();

   assign if1.in_valid  = d_valid & ~sel;
   assign if1.in_sign   = d_sign;
   assign if1.in_exp    = d_exp;
   assign if1.in_mant   = d_mant;
   assign if1.out_ready = d_out_ready & ~sel;
   assign if4.in_valid  = d_valid & sel;
   assign if4.in_sign   = d_sign;
   assign if4.in_exp    = d_exp;
   assign if4.in_mant   = d_mant;
   assign if4.out_ready = d_out_ready & sel;

   fp_add_normalize_pack #(.SHIFTS_PER_CYCLE(1)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .io_bus  (if1.slave)
   );

   fp_add_normalize_pack #(.SHIFTS_PER_CYCLE(4)) u_dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .io_bus  (if4.slave)
   );

   wire        o_in_ready = sel ? if4.in_ready   : if1.in_ready;
   wire        o_valid    = sel ? if4.out_valid  : if1.out_valid;
   wire [31:0] o_result   = sel ? if4.out_result : if1.out_result;
   wire [2:0]  o_flags    = sel ? if4.out_flags  : if1.out_flags;
   wire [4:0]  o_shift    = sel ? if4.out_shift  : if1.out_shift;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flags;
      logic [4:0]  shift;
      int          lat;
   } expect_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
      end
   endtask

   // Arithmetic view: count leading zeros, see how far the exponent can drop.
   function automatic expect_t model(input bit s, input bit [7:0] e, input bit [24:0] m,
                                     input int spc);
      expect_t x;
      int lz, room, ne;
      bit [24:0] t;
      x.res = '0; x.flags = '0; x.shift = '0; x.lat = 1;
      if (e == 8'hFF) begin
         x.res = {s, 8'hFF, 23'h0}; x.flags = 3'b100;
      end else if (m == 0) begin
         x.flags = 3'b001;
      end else if (m[24]) begin
         ne = int'(e) + 1;
         if (ne >= 255) begin
            x.res = {s, 8'hFF, 23'h0}; x.flags = 3'b100;
         end else begin
            x.res = {s, 8'(ne), m[23:1]};
         end
      end else if (m[23]) begin
         x.res = {s, e, m[22:0]};
      end else begin
         lz = 0;
         for (int i = 23; i >= 0; i--) begin
            if (m[i]) break;
            lz++;
         end
         room = (e > 0) ? int'(e) - 1 : 0;
         if (lz <= room) begin
            t       = m << lz;
            x.res   = {s, 8'(int'(e) - lz), t[22:0]};
            x.shift = 5'(lz);
            x.lat   = 1 + (lz + spc - 1) / spc;
         end else begin
            x.res   = {s, 31'h0};
            x.flags = 3'b010;
            x.shift = 5'(room);
            x.lat   = 1 + (room + 1 + spc - 1) / spc;
         end
      end
      return x;
   endfunction

   // One transaction; hold = cycles out_ready stays low once the result shows.
   task automatic do_txn(input bit s, input bit [7:0] e, input bit [24:0] m, input int hold);
      expect_t x;
      int n, lat;
      x = model(s, e, m, sel ? 4 : 1);
      @(negedge clk);
      d_out_ready = (hold == 0);
      d_valid = 1'b1; d_sign = s; d_exp = e; d_mant = m;
      n = 0;
      while (!o_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", 32'(n < 50), 32'd1);
      @(negedge clk);
      d_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, x.lat);
      check("result", o_result, x.res);
      check("flags", 32'(o_flags), 32'(x.flags));
      check("shift", 32'(o_shift), 32'(x.shift));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(o_valid), 32'd1);
         check("hold_result", o_result, x.res);
         check("hold_in_ready", 32'(o_in_ready), 32'd0);
      end
      d_out_ready = 1'b1;
      @(negedge clk);
      check("consumed", 32'(o_valid), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit        s;
      bit [7:0]  e;
      bit [24:0] m;
      int        kind;
      bit        seen;

      // Reset state
      #12;
      check("rst_valid1", 32'(if1.out_valid), 32'd0);
      check("rst_result1", if1.out_result, 32'd0);
      check("rst_flags1", 32'(if1.out_flags), 32'd0);
      check("rst_shift1", 32'(if1.out_shift), 32'd0);
      check("rst_valid4", 32'(if4.out_valid), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(o_in_ready), 32'd1);

      // Directed points
      sel = 1'b0;
      do_txn(1'b0, 8'h7F, 25'h0800000, 0);   // 1.0
      check("dir_one", o_result, 32'h3F800000);  // still held (valid dropped)
      do_txn(1'b0, 8'h7F, 25'h1000000, 0);   // 2.0 via carry
      check("dir_two", o_result, 32'h40000000);
      do_txn(1'b1, 8'h80, 25'h0400000, 0);   // -1.0 after one left shift
      check("dir_neg_one", o_result, 32'hBF800000);
      do_txn(1'b1, 8'h85, 25'h0000000, 0);   // zero, sign dropped
      do_txn(1'b0, 8'hFE, 25'h1000000, 0);   // carry into infinity
      check("dir_inf", o_result, 32'h7F800000);
      do_txn(1'b1, 8'h02, 25'h0000001, 0);   // flush to zero, sign kept
      check("dir_unf", o_result, 32'h80000000);
      do_txn(1'b0, 8'hFF, 25'h0000000, 0);   // FF wins over zero mantissa
      sel = 1'b1;
      do_txn(1'b0, 8'h90, 25'h0000100, 0);   // 15 shifts at 4 per cycle
      check("dir_s4", o_result, 32'h40800000);

      // Stall in DONE, then release together with the next input
      sel = 1'b0;
      do_txn(1'b0, 8'h7F, 25'h0800000, 5);
      @(negedge clk);
      d_out_ready = 1'b0;
      d_valid = 1'b1; d_sign = 1'b0; d_exp = 8'h7F; d_mant = 25'h0800000;
      @(negedge clk);
      d_valid = 1'b0;
      check("b2b_first_valid", 32'(o_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("b2b_stall_in_ready", 32'(o_in_ready), 32'd0);
         check("b2b_stall_result", o_result, 32'h3F800000);
      end
      d_out_ready = 1'b1;
      d_valid = 1'b1; d_sign = 1'b0; d_exp = 8'h7F; d_mant = 25'h1000000;
      #1;
      check("b2b_in_ready", 32'(o_in_ready), 32'd1);
      @(negedge clk);
      d_valid = 1'b0;
      check("b2b_second_valid", 32'(o_valid), 32'd1);
      check("b2b_second_result", o_result, 32'h40000000);
      @(negedge clk);
      check("b2b_drained", 32'(o_valid), 32'd0);

      // Reset while normalizing abandons the result
      d_valid = 1'b1; d_sign = 1'b0; d_exp = 8'h90; d_mant = 25'h0000100;
      @(negedge clk);
      d_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #3 reset_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      check("rst_mid_norm_no_output", 32'(seen), 32'd0);
      check("rst_mid_norm_result", o_result, 32'd0);
      check("rst_mid_norm_in_ready", 32'(o_in_ready), 32'd1);

      // Randomized traffic over all decode paths
      for (int k = 0; k < 300; k++) begin
         sel  = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 5);
         s    = 1'($urandom);
         e    = 8'($urandom_range(0, 254));
         m    = {1'b0, 24'($urandom)};
         case (kind)
            0: e = 8'hFF;
            1: m = '0;
            2: begin
               m[24] = 1'b1;
               if ($urandom_range(0, 3) == 0) e = 8'hFE;
            end
            3: m[24:23] = 2'b01;
            default: begin
               m[24:23] = 2'b00;
               m = m >> $urandom_range(0, 23);
               if (m == 0) m = 25'd1;
               if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(0, 24));
            end
         endcase
         do_txn(s, e, m, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
